// File: rtl/shift_reg_pkg.sv
// Shared MODE encoding and burst FSM state type for the universal shift register.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    function automatic logic is_shift(input logic [1:0] mode);
        return (mode == MODE_SHL) || (mode == MODE_SHR);
    endfunction

endpackage

// File: rtl/shift_core.sv
// WIDTH-bit register with hold/shift-left/shift-right/load next-value mux; SHIFT_REG_ROTATE_EN turns shifts into rotates.
// Latency: 1 cycle from op to q.
// Backpressure: none; en low freezes the register.
module shift_core
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             en,
    input  logic [1:0]       op,
    input  logic             sl,
    input  logic             sr,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] q
);

    logic             fill_l;
    logic             fill_r;
    logic [WIDTH-1:0] q_nxt;

`ifdef SHIFT_REG_ROTATE_EN
    // Serial inputs stay on the port list but do not feed the register.
    logic unused_serial;
    assign unused_serial = sl ^ sr;
    assign fill_l        = q[WIDTH-1];
    assign fill_r        = q[0];
`else
    assign fill_l = sl;
    assign fill_r = sr;
`endif

    always_comb begin
        q_nxt = q;
        case (op)
            MODE_SHL:  q_nxt = {q[WIDTH-2:0], fill_l};
            MODE_SHR:  q_nxt = {fill_r, q[WIDTH-1:1]};
            MODE_LOAD: q_nxt = p;
            default:   q_nxt = q;
        endcase
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            q <= '0;
        end else if (en) begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register with counted shift bursts (IDLE/BURST FSM); SHIFT_REG_ROTATE_EN selects rotate instead of serial fill.
// Latency: 1 cycle per operation; a burst of CNT shifts completes on the CNT-th enabled edge.
// Backpressure: EN low freezes register, FSM and counter; BUSY flags an active burst.
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             C,
    input  logic             nR,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             SL,
    input  logic             SR,
    input  logic [WIDTH-1:0] P,
    input  logic             START,
    input  logic [CW-1:0]    CNT,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] nQ,
    output logic             SO_L,
    output logic             SO_R,
    output logic             BUSY
);

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      dir_q;
    logic [CW-1:0]   cnt_sat;
    logic            burst_req;
    logic [1:0]      core_op;

    assign cnt_sat   = (CNT > CNT_MAX) ? CNT_MAX : CNT;
    assign burst_req = START && (cnt_sat != '0) && is_shift(MODE);

    // During a burst the latched direction drives the core and MODE is ignored.
    always_comb begin
        core_op = MODE;
        if (state_q == ST_BURST) begin
            core_op = dir_q;
        end
    end

    // cnt_q holds the shifts still owed after the current edge while in BURST.
    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= MODE_SHL;
        end else if (EN) begin
            case (state_q)
                ST_IDLE: begin
                    if (burst_req) begin
                        dir_q <= MODE;
                        if (cnt_sat > CNT_ONE) begin
                            state_q <= ST_BURST;
                            cnt_q   <= cnt_sat - CNT_ONE;
                        end
                    end
                end
                ST_BURST: begin
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .core_clk (C),
        .arst_n   (nR),
        .en       (EN),
        .op       (core_op),
        .sl       (SL),
        .sr       (SR),
        .p        (P),
        .q        (Q)
    );

    assign nQ   = ~Q;
    assign SO_L = Q[WIDTH-1];
    assign SO_R = Q[0];
    assign BUSY = (state_q == ST_BURST);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ (WIDTH=4): directed scenarios plus randomized traffic
// against a shift-count reference model.
module tb_shift_reg_univ;

    localparam int WIDTH = 4;
    localparam int CW    = 3;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [1:0]       mode;
    logic             sl;
    logic             sr;
    logic [WIDTH-1:0] p;
    logic             start;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nq;
    logic             so_l;
    logic             so_r;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    // Reference model: register value as an integer, plus shifts still owed by a burst.
    int mq       = 0;
    int owed     = 0;
    int mdir     = 1;

    shift_reg_univ #(.WIDTH(WIDTH)) dut (
        .C     (clk),
        .nR    (rst_n),
        .EN    (en),
        .MODE  (mode),
        .SL    (sl),
        .SR    (sr),
        .P     (p),
        .START (start),
        .CNT   (cnt),
        .Q     (q),
        .nQ    (nq),
        .SO_L  (so_l),
        .SO_R  (so_r),
        .BUSY  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int shifted(input int v, input int dir, input int s_l, input int s_r);
`ifdef SHIFT_REG_ROTATE_EN
        if (dir == 1) return (v * 2) % 16 + v / 8;
        return v / 2 + (v % 2) * 8;
`else
        if (dir == 1) return (v * 2) % 16 + s_l;
        return v / 2 + s_r * 8;
`endif
    endfunction

    task automatic model_step();
        int c;
        if (!en) return;
        if (owed > 0) begin
            mq = shifted(mq, mdir, int'(sl), int'(sr));
            owed--;
        end else begin
            c = (int'(cnt) > WIDTH) ? WIDTH : int'(cnt);
            case (int'(mode))
                3: mq = int'(p);
                1, 2: begin
                    mq = shifted(mq, int'(mode), int'(sl), int'(sr));
                    if (start && c > 0) begin
                        mdir = int'(mode);
                        owed = c - 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"},    32'(q),    32'(mq));
        chk({tag, ".nq"},   32'(nq),   32'(15 - mq));
        chk({tag, ".so_l"}, 32'(so_l), 32'(mq / 8));
        chk({tag, ".so_r"}, 32'(so_r), 32'(mq % 2));
        chk({tag, ".busy"}, 32'(busy), 32'(owed > 0));
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic s_l, input logic s_r,
                         input logic [WIDTH-1:0] pv, input logic st, input logic [CW-1:0] c);
        en = e; mode = m; sl = s_l; sr = s_r; p = pv; start = st; cnt = c;
    endtask

    // Inputs are applied at the falling edge; outputs are compared at the next falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        mq   = 0;
        owed = 0;
        chk({tag, ".q"},    32'(q),    32'h0);
        chk({tag, ".nq"},   32'(nq),   32'hf);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int busy_cycles;
        rst_n = 1'b0;
        drive(1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0);
        #1;
        chk("rst_init.q",    32'(q),    32'h0);
        chk("rst_init.nq",   32'(nq),   32'hf);
        chk("rst_init.busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Parallel load then hold.
        drive(1'b1, 2'b11, 1'b0, 1'b0, 4'b1010, 1'b0, 3'd0);
        tick("load");
        chk("load.const", 32'(q), 32'b1010);
        chk("load.so_l",  32'(so_l), 32'h1);
        chk("load.so_r",  32'(so_r), 32'h0);
        drive(1'b1, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0);
        tick("hold1");
        tick("hold2");
        chk("hold.const", 32'(q), 32'b1010);

        // Left burst of 3 with SL=1: 1010 -> 0101 -> 1011 -> 0111, BUSY high for 2 samples.
        drive(1'b1, 2'b01, 1'b1, 1'b0, 4'h0, 1'b1, 3'd3);
        tick("bl1");
        drive(1'b1, 2'b11, 1'b1, 1'b0, 4'h5, 1'b1, 3'd1);
        tick("bl2");
        tick("bl3");
        chk("bl.final", 32'(q), 32'b0111);
        chk("bl.idle",  32'(busy), 32'h0);

        // Right burst of 4 with two stalled cycles in the middle.
        drive(1'b1, 2'b11, 1'b0, 1'b0, 4'b1001, 1'b0, 3'd0);
        tick("br_ld");
        busy_cycles = 0;
        drive(1'b1, 2'b10, 1'b0, 1'b1, 4'h0, 1'b1, 3'd4);
        tick("br1"); busy_cycles += int'(busy);
        drive(1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0);
        tick("br2"); busy_cycles += int'(busy);
        en = 1'b0;
        tick("br_st1"); busy_cycles += int'(busy);
        tick("br_st2"); busy_cycles += int'(busy);
        en = 1'b1; sr = 1'b1;
        tick("br3"); busy_cycles += int'(busy);
        tick("br4"); busy_cycles += int'(busy);
        chk("br.busy_len", 32'(busy_cycles), 32'd5);

        // Reset pulse after two shifts of a 4-shift burst aborts it.
        drive(1'b1, 2'b11, 1'b0, 1'b0, 4'b1111, 1'b0, 3'd0);
        tick("ra_ld");
        drive(1'b1, 2'b01, 1'b1, 1'b1, 4'h0, 1'b1, 3'd4);
        tick("ra1");
        drive(1'b1, 2'b00, 1'b1, 1'b1, 4'h0, 1'b0, 3'd0);
        tick("ra2");
        async_reset("ra_rst");
        tick("ra_after1");
        tick("ra_after2");
        chk("ra.zero", 32'(q), 32'h0);

        // Single left shift of 1000 yields 0001 (serial fill 1, or rotate ignoring SL).
        drive(1'b1, 2'b11, 1'b0, 1'b0, 4'b1000, 1'b0, 3'd0);
        tick("rot_ld");
`ifdef SHIFT_REG_ROTATE_EN
        drive(1'b1, 2'b01, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0);
`else
        drive(1'b1, 2'b01, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0);
`endif
        tick("rot1");
        chk("rot.const", 32'(q), 32'b0001);

        // Oversized CNT saturates to WIDTH shifts.
        drive(1'b1, 2'b10, 1'b0, 1'b0, 4'h0, 1'b1, 3'd7);
        tick("sat1");
        drive(1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) tick("sat_n");

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            drive(($urandom % 5) != 0, 2'($urandom), 1'($urandom), 1'($urandom),
                  4'($urandom), ($urandom % 3) == 0, 3'($urandom_range(0, 7)));
            if (($urandom % 60) == 0) async_reset("rnd_rst");
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
